// File: rtl/pll_mon_pkg.sv
// Shared state encoding and default sizing for the PLL lock monitor.
// Latency and backpressure: none (constants only).
package pll_mon_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam int WIN_CYCLES_DEF = 256;
  localparam int CNT_W_DEF      = 10;
  localparam int TOL_DEF        = 2;
  localparam int LOCK_N_DEF     = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge pulse for an async input.
// Latency: input rise to edge_pulse is 3 osc cycles; no backpressure.
module sync_edge_det (
  input  logic osc,
  input  logic resetb,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge osc) begin
    if (!resetb) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      sync2_d    <= sync2;
      edge_pulse <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// Counts clkfb rises per window of osc cycles and flags lock / too fast / too slow.
// Results register one cycle after each MEASURE window ends; no backpressure.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_N     = LOCK_N_DEF
) (
  input  logic             osc,
  input  logic             resetb,
  input  logic             enable,
  input  logic             clkfb,
  input  logic [CNT_W-1:0] expected,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             too_fast,
  output logic             too_slow
);

  localparam int WIN_W   = $clog2(WIN_CYCLES);
  localparam int MATCH_W = $clog2(LOCK_N + 1);

  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W:0]     TOL_X    = (CNT_W + 1)'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_N);

  logic [1:0]         state;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic               edge_pulse;

  logic               win_end;
  logic [CNT_W-1:0]   cnt_final;
  logic [CNT_W:0]     exp_x;
  logic [CNT_W:0]     cnt_x;
  logic [CNT_W:0]     hi_lim;
  logic [CNT_W:0]     lo_lim;
  logic               fast_now;
  logic               slow_now;
  logic [MATCH_W-1:0] match_next;

  sync_edge_det u_sync_edge_det (
    .osc        (osc),
    .resetb     (resetb),
    .async_in   (clkfb),
    .edge_pulse (edge_pulse)
  );

  // An edge landing on the last window cycle is folded into the ending count.
  always_comb begin
    win_end    = (win_cnt == WIN_LAST);
    cnt_final  = edge_cnt;
    if (edge_pulse && (edge_cnt != CNT_MAX)) begin
      cnt_final = edge_cnt + 1'b1;
    end
    exp_x      = {1'b0, expected};
    cnt_x      = {1'b0, cnt_final};
    hi_lim     = exp_x + TOL_X;
    lo_lim     = (exp_x >= TOL_X) ? (exp_x - TOL_X) : '0;
    fast_now   = (cnt_x > hi_lim);
    slow_now   = (cnt_x < lo_lim);
    match_next = (match_cnt == LOCK_TGT) ? match_cnt : (match_cnt + 1'b1);
  end

  always_ff @(posedge osc) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      match_cnt  <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      too_fast   <= 1'b0;
      too_slow   <= 1'b0;
    end else if (!enable) begin
      // meas_count deliberately holds so firmware can still read the last result.
      state      <= ST_IDLE;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      match_cnt  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      too_fast   <= 1'b0;
      too_slow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state    <= ST_SETTLE;
          win_cnt  <= '0;
          edge_cnt <= '0;
        end
        ST_SETTLE, ST_MEASURE: begin
          win_cnt  <= win_end ? '0 : (win_cnt + 1'b1);
          edge_cnt <= win_end ? '0 : cnt_final;
          if (win_end) begin
            if (state == ST_SETTLE) begin
              state <= ST_MEASURE;
            end else begin
              meas_count <= cnt_final;
              meas_valid <= 1'b1;
              too_fast   <= fast_now;
              too_slow   <= slow_now;
              if (fast_now || slow_now) begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end else begin
                match_cnt <= match_next;
                locked    <= (match_next == LOCK_TGT);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized bench for pll_lock_monitor with a window-level reference model.
// Two instances: default sizing and a 6-bit count to exercise saturation.
module tb_pll_lock_monitor;

  localparam int W      = 256;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;

  logic       osc = 1'b0;
  logic       resetb;
  logic       enable;
  logic       clkfb;
  logic [9:0] expected0;
  logic [5:0] expected1;
  logic [9:0] meas_count0;
  logic [5:0] meas_count1;
  logic       meas_valid0, locked0, too_fast0, too_slow0;
  logic       meas_valid1, locked1, too_fast1, too_slow1;

  pll_lock_monitor u_dut0 (
    .osc        (osc),
    .resetb     (resetb),
    .enable     (enable),
    .clkfb      (clkfb),
    .expected   (expected0),
    .meas_count (meas_count0),
    .meas_valid (meas_valid0),
    .locked     (locked0),
    .too_fast   (too_fast0),
    .too_slow   (too_slow0)
  );

  pll_lock_monitor #(.CNT_W(6)) u_dut1 (
    .osc        (osc),
    .resetb     (resetb),
    .enable     (enable),
    .clkfb      (clkfb),
    .expected   (expected1),
    .meas_count (meas_count1),
    .meas_valid (meas_valid1),
    .locked     (locked1),
    .too_fast   (too_fast1),
    .too_slow   (too_slow1)
  );

  initial forever #10 osc = ~osc;

  int vectors     = 0;
  int miscompares = 0;

  // clkfb toggles only on osc falling edges, so every rising edge samples a stable level.
  int half   = 2;
  bit jitter = 1'b0;
  int clk_h;
  initial begin
    clkfb = 1'b0;
    forever begin
      clk_h = jitter ? int'($urandom_range(5, 1)) : half;
      repeat (clk_h) @(negedge osc);
      clkfb = ~clkfb;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // Reference model: the level clkfb held at each osc rise, plus the index of
  // the rise where enable was first seen high. A result is due every W cycles
  // from 2W on, covering rises seen W+2..3 samples earlier (sync delay).
  bit smp [0:65535];
  int cyc      = 0;
  int run      = -1;
  bit model_ok = 1'b0;
  int e_cnt [2];
  bit e_vld [2];
  bit e_lk  [2];
  bit e_tf  [2];
  bit e_ts  [2];
  int mrun  [2];
  int maxv  [2] = '{1023, 63};
  int d, rises, c, ev;

  always @(posedge osc) begin
    cyc++;
    smp[cyc] = (resetb === 1'b1) ? clkfb : 1'b0;
    if (resetb !== 1'b1) begin
      run = -1;
      for (int i = 0; i < 2; i++) begin
        e_cnt[i] = 0; e_vld[i] = 0; e_lk[i] = 0; e_tf[i] = 0; e_ts[i] = 0; mrun[i] = 0;
      end
      model_ok = 1'b1;
    end else if (enable !== 1'b1) begin
      run = -1;
      for (int i = 0; i < 2; i++) begin
        e_vld[i] = 0; e_lk[i] = 0; e_tf[i] = 0; e_ts[i] = 0; mrun[i] = 0;
      end
    end else if (run < 0) begin
      run = cyc;
      for (int i = 0; i < 2; i++) e_vld[i] = 0;
    end else begin
      d = cyc - run;
      if (d >= 2 * W && (d % W) == 0) begin
        rises = 0;
        for (int q = cyc - W - 2; q <= cyc - 3; q++)
          if (smp[q] && !smp[q-1]) rises++;
        for (int i = 0; i < 2; i++) begin
          ev       = (i == 0) ? int'(expected0) : int'(expected1);
          c        = (rises > maxv[i]) ? maxv[i] : rises;
          e_tf[i]  = (c > ev + TOL);
          e_ts[i]  = (c < ev - TOL);
          mrun[i]  = (e_tf[i] || e_ts[i]) ? 0 : mrun[i] + 1;
          e_lk[i]  = (mrun[i] >= LOCK_N);
          e_cnt[i] = c;
          e_vld[i] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 2; i++) e_vld[i] = 0;
      end
    end
  end

  always @(negedge osc) begin
    if (model_ok) begin
      vectors++;
      cmp("count0", 32'(meas_count0), e_cnt[0]);
      cmp("valid0", 32'(meas_valid0), 32'(e_vld[0]));
      cmp("locked0", 32'(locked0), 32'(e_lk[0]));
      cmp("fast0", 32'(too_fast0), 32'(e_tf[0]));
      cmp("slow0", 32'(too_slow0), 32'(e_ts[0]));
      cmp("count1", 32'(meas_count1), e_cnt[1]);
      cmp("valid1", 32'(meas_valid1), 32'(e_vld[1]));
      cmp("locked1", 32'(locked1), 32'(e_lk[1]));
      cmp("fast1", 32'(too_fast1), 32'(e_tf[1]));
      cmp("slow1", 32'(too_slow1), 32'(e_ts[1]));
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge osc);
      k++;
    end while (meas_valid0 !== 1'b1 && k < 2000);
    if (meas_valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_timeout: no meas_valid within %0d cycles", k);
    end
  endtask

  int k;
  int v;

  initial begin
    resetb    = 1'b0;
    enable    = 1'b0;
    expected0 = 10'd64;
    expected1 = 6'd63;

    repeat (5) @(negedge osc);
    cmp("rst_count", 32'(meas_count0), 0);
    cmp("rst_valid", 32'(meas_valid0), 0);
    cmp("rst_locked", 32'(locked0), 0);
    cmp("rst_fast", 32'(too_fast0), 0);
    cmp("rst_slow", 32'(too_slow0), 0);
    resetb = 1'b1;
    repeat (2) @(negedge osc);

    // 80 ns feedback, expected 64: first result latency, then lock on the 4th.
    enable = 1'b1;
    wait_valid(k);
    cmp("first_valid_latency", 32'(k), 513);
    cmp("lock_count", 32'(meas_count0), 64);
    cmp("lock_flags", 32'({too_fast0, too_slow0}), 0);
    cmp("sat_count", 32'(meas_count1), 63);
    cmp("sat_fast", 32'(too_fast1), 0);
    for (int n = 2; n <= 4; n++) begin
      wait_valid(k);
      cmp("lock_count", 32'(meas_count0), 64);
      cmp("lock_rise", 32'(locked0), (n == 4) ? 1 : 0);
    end

    // Feedback doubles: the mixed window already misses, the next full one reads 128.
    half = 1;
    wait_valid(k);
    cmp("loss_fast", 32'(too_fast0), 1);
    cmp("loss_locked", 32'(locked0), 0);
    wait_valid(k);
    cmp("loss_count", 32'(meas_count0), 128);
    cmp("loss_fast_full", 32'(too_fast0), 1);

    // Slow against expected 70, then within tolerance of 66.
    half      = 2;
    expected0 = 10'd70;
    wait_valid(k);
    wait_valid(k);
    cmp("slow_count", 32'(meas_count0), 64);
    cmp("slow_flags", 32'({too_fast0, too_slow0}), 1);
    cmp("slow_locked", 32'(locked0), 0);
    expected0 = 10'd66;
    for (int n = 1; n <= 4; n++) begin
      wait_valid(k);
      cmp("tol_flags", 32'({too_fast0, too_slow0}), 0);
      cmp("tol_locked", 32'(locked0), (n == 4) ? 1 : 0);
    end

    // Abort mid-window while locked, then restart from SETTLE.
    repeat (100) @(negedge osc);
    enable = 1'b0;
    @(negedge osc);
    cmp("abort_locked", 32'(locked0), 0);
    cmp("abort_flags", 32'({too_fast0, too_slow0}), 0);
    cmp("abort_count_hold", 32'(meas_count0), 64);
    repeat (10) @(negedge osc);
    enable = 1'b1;
    wait_valid(k);
    cmp("reenable_latency", 32'(k), 513);

    // Randomized feedback rates, targets, jitter and enable drops.
    for (int it = 0; it < 30; it++) begin
      half   = int'($urandom_range(6, 1));
      jitter = ($urandom_range(2, 0) == 0);
      v      = W / (2 * half) + int'($urandom_range(8, 0)) - 4;
      if ($urandom_range(3, 0) == 0) v = int'($urandom_range(200, 0));
      expected0 = 10'(v);
      expected1 = 6'($urandom_range(63, 0));
      if ($urandom_range(5, 0) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(20, 1)) @(negedge osc);
        enable = 1'b1;
      end
      repeat ($urandom_range(600, 100)) @(negedge osc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
